// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader.
//   - default widths and the section-size limit
//   - byte order of the incoming stream (low byte first)
//   - loader FSM state enumeration (15 states)
package loader_pkg;

    localparam int ADDR_W_DEF    = 9;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_WORDS_DEF = 512;

    // Stream carries the least-significant byte of every 16-bit field first.
    localparam bit LSB_FIRST = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ICNT_LO,
        ST_ICNT_HI,
        ST_I_LO,
        ST_I_HI,
        ST_I_WR,
        ST_I_HOLD,
        ST_DCNT_LO,
        ST_DCNT_HI,
        ST_D_LO,
        ST_D_HI,
        ST_D_WR,
        ST_D_HOLD,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: builds a DATA_W word from two stream bytes.
//   clock, reset_n : clock and synchronous active-low reset
//   byte_in        : current stream byte
//   lo_stb, hi_stb : capture byte_in as the low / high byte this cycle
//   word           : word as it will be after this edge (current byte merged
//                    in), so the FSM can act on a field the same cycle its
//                    last byte arrives
module word_assembler
    import loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        byte_in,
    input  logic              lo_stb,
    input  logic              hi_stb,
    output logic [DATA_W-1:0] word
);

    localparam int LO_POS = LSB_FIRST ? 0 : 8;
    localparam int HI_POS = LSB_FIRST ? 8 : 0;

    logic [DATA_W-1:0] word_q;

    always_comb begin
        word = word_q;
        if (lo_stb) word[LO_POS +: 8] = byte_in;
        if (hi_stb) word[HI_POS +: 8] = byte_in;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) word_q <= '0;
        else          word_q <= word;
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader feeding the multicore memory-load
// interface. Stream: icount, icount words, dcount, dcount words (all 16-bit,
// low byte first). Instruction words go to IRAM via start_2, data words to
// DRAM via start_3, then start is held high until the next load_req.
//   clock, reset_n           : clock, synchronous active-low reset
//   load_req                 : begin a new load (from IDLE, RUN or ERR)
//   rx_data/rx_valid/rx_ready: byte stream handshake
//   addr_ext                 : IRAM/DRAM word address
//   start_2/iram_write_ext/data_ins  : IRAM load select, write, data
//   start_3/dram_write_ext/data_dram : DRAM load select, write, data
//   start                    : processor run level
//   busy                     : load in progress
//   error                    : oversize section count, held until load_req
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              start_2,
    output logic              iram_write_ext,
    output logic [DATA_W-1:0] data_ins,
    output logic              start_3,
    output logic              dram_write_ext,
    output logic [DATA_W-1:0] data_dram,
    output logic              start,
    output logic              busy,
    output logic              error
);

    localparam logic [DATA_W-1:0] MAX_CNT = DATA_W'(MAX_WORDS);

    state_t            state;
    state_t            nxt;
    logic [DATA_W-1:0] count_q;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] asm_word;
    logic              accept;
    logic              lo_stb;
    logic              hi_stb;
    logic              last_word;
    logic              cnt_done;

    function automatic logic is_collect(input state_t s);
        return s inside {ST_ICNT_LO, ST_ICNT_HI, ST_I_LO, ST_I_HI,
                         ST_DCNT_LO, ST_DCNT_HI, ST_D_LO, ST_D_HI};
    endfunction

    function automatic logic is_busy(input state_t s);
        return !(s inside {ST_IDLE, ST_RUN, ST_ERR});
    endfunction

    // rx_ready is a registered copy of is_collect(state).
    assign accept    = rx_valid && rx_ready;
    assign lo_stb    = accept && (state inside {ST_ICNT_LO, ST_I_LO, ST_DCNT_LO, ST_D_LO});
    assign hi_stb    = accept && (state inside {ST_ICNT_HI, ST_I_HI, ST_DCNT_HI, ST_D_HI});
    assign cnt_done  = accept && (state inside {ST_ICNT_HI, ST_DCNT_HI});
    assign last_word = (DATA_W'(word_addr) == (count_q - DATA_W'(1)));

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clock   (clock),
        .reset_n (reset_n),
        .byte_in (rx_data),
        .lo_stb  (lo_stb),
        .hi_stb  (hi_stb),
        .word    (asm_word)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: if (load_req) nxt = ST_ICNT_LO;
            ST_ICNT_LO: if (accept) nxt = ST_ICNT_HI;
            ST_ICNT_HI: if (accept) begin
                if (asm_word > MAX_CNT)  nxt = ST_ERR;
                else if (asm_word == '0) nxt = ST_DCNT_LO;
                else                     nxt = ST_I_LO;
            end
            ST_I_LO:    if (accept) nxt = ST_I_HI;
            ST_I_HI:    if (accept) nxt = ST_I_WR;
            ST_I_WR:    nxt = ST_I_HOLD;
            ST_I_HOLD:  nxt = last_word ? ST_DCNT_LO : ST_I_LO;
            ST_DCNT_LO: if (accept) nxt = ST_DCNT_HI;
            ST_DCNT_HI: if (accept) begin
                if (asm_word > MAX_CNT)  nxt = ST_ERR;
                else if (asm_word == '0) nxt = ST_RUN;
                else                     nxt = ST_D_LO;
            end
            ST_D_LO:    if (accept) nxt = ST_D_HI;
            ST_D_HI:    if (accept) nxt = ST_D_WR;
            ST_D_WR:    nxt = ST_D_HOLD;
            ST_D_HOLD:  nxt = last_word ? ST_RUN : ST_D_LO;
            default:    nxt = ST_IDLE;
        endcase
    end

    // All outputs are registered decodes of the next state, so they line up
    // with the state register and are glitch-free.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            count_q        <= '0;
            word_addr      <= '0;
            rx_ready       <= 1'b0;
            busy           <= 1'b0;
            start          <= 1'b0;
            start_2        <= 1'b0;
            start_3        <= 1'b0;
            iram_write_ext <= 1'b0;
            dram_write_ext <= 1'b0;
            error          <= 1'b0;
            addr_ext       <= '0;
            data_ins       <= '0;
            data_dram      <= '0;
        end else begin
            state          <= nxt;
            rx_ready       <= is_collect(nxt);
            busy           <= is_busy(nxt);
            start          <= (nxt == ST_RUN);
            start_2        <= (nxt == ST_I_WR) || (nxt == ST_I_HOLD);
            start_3        <= (nxt == ST_D_WR) || (nxt == ST_D_HOLD);
            iram_write_ext <= (nxt == ST_I_WR);
            dram_write_ext <= (nxt == ST_D_WR);
            error          <= (nxt == ST_ERR);

            if (cnt_done) begin
                count_q   <= asm_word;
                word_addr <= '0;
            end

            if ((state == ST_I_HOLD || state == ST_D_HOLD) && !last_word)
                word_addr <= word_addr + ADDR_W'(1);

            // Address and data are latched only when a word's write begins,
            // keeping them steady through WR/HOLD and until the next write.
            if (nxt == ST_I_WR) begin
                addr_ext <= word_addr;
                data_ins <= asm_word;
            end
            if (nxt == ST_D_WR) begin
                addr_ext  <= word_addr;
                data_dram <= asm_word;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stimulus with a write scoreboard for prog_loader.
// Expected IRAM/DRAM writes are queued as each stream is issued; a monitor
// pops and compares on every write pulse and checks the following hold cycle.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [8:0]  addr_ext;
    logic        start_2, iram_write_ext, start_3, dram_write_ext;
    logic [15:0] data_ins, data_dram;
    logic        start, busy, error;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [24:0] iram_q[$];   // {addr, data}
    logic [24:0] dram_q[$];

    always #5 clock = ~clock;

    prog_loader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load_req       (load_req),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .addr_ext       (addr_ext),
        .start_2        (start_2),
        .iram_write_ext (iram_write_ext),
        .data_ins       (data_ins),
        .start_3        (start_3),
        .dram_write_ext (dram_write_ext),
        .data_dram      (data_dram),
        .start          (start),
        .busy           (busy),
        .error          (error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        pw_i = 1'b0, pw_d = 1'b0;
    logic [8:0]  pa_i, pa_d;
    logic [15:0] pd_i, pd_d;
    logic [24:0] e;

    always @(negedge clock) begin
        if (int'(start) + int'(start_2) + int'(start_3) > 1)
            chk("select_exclusive", {29'd0, start, start_2, start_3}, 32'd0);
        if (pw_i) begin
            chk("iram_hold_sel", start_2, 1);
            chk("iram_hold_we", iram_write_ext, 0);
            chk("iram_hold_addr", addr_ext, pa_i);
            chk("iram_hold_data", data_ins, pd_i);
        end
        if (pw_d) begin
            chk("dram_hold_sel", start_3, 1);
            chk("dram_hold_we", dram_write_ext, 0);
            chk("dram_hold_addr", addr_ext, pa_d);
            chk("dram_hold_data", data_dram, pd_d);
        end
        if (iram_write_ext) begin
            chk("iram_wr_sel", start_2, 1);
            if (iram_q.size() == 0) chk("iram_unexpected_wr", {7'd0, addr_ext, data_ins}, 32'hFFFF_FFFF);
            else begin
                e = iram_q.pop_front();
                chk("iram_addr", addr_ext, e[24:16]);
                chk("iram_data", data_ins, e[15:0]);
            end
        end
        if (dram_write_ext) begin
            chk("dram_wr_sel", start_3, 1);
            if (dram_q.size() == 0) chk("dram_unexpected_wr", {7'd0, addr_ext, data_dram}, 32'hFFFF_FFFF);
            else begin
                e = dram_q.pop_front();
                chk("dram_addr", addr_ext, e[24:16]);
                chk("dram_data", data_dram, e[15:0]);
            end
        end
        pw_i = iram_write_ext; pa_i = addr_ext; pd_i = data_ins;
        pw_d = dram_write_ext; pa_d = addr_ext; pd_d = data_dram;
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic r;
        bit   done = 0;
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            r = rx_ready;
            @(negedge clock);
            if (r) done = 1;
        end
        if (!done) chk("byte_timeout", 0, 1);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gap);
        foreach (s[i]) send_byte(s[i], gap);
        rx_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 40 && !start; n++) @(negedge clock);
        chk("wait_start", start, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        logic [15:0] w;

        // reset
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", rx_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_addr", addr_ext, 0);
        @(negedge clock);

        // basic image
        iram_q.push_back({9'd0, 16'h1234});
        iram_q.push_back({9'd1, 16'h5678});
        dram_q.push_back({9'd0, 16'hBEEF});
        pulse_load();
        chk("t1_busy", busy, 1);
        chk("t1_ready", rx_ready, 1);
        s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h01, 8'h00, 8'hEF, 8'hBE};
        send_stream(s, 0);
        chk("t1_dwr_we", dram_write_ext, 1);
        @(negedge clock);
        chk("t1_dhold_start", start, 0);
        @(negedge clock);
        chk("t1_run_start", start, 1);
        chk("t1_run_busy", busy, 0);
        chk("t1_run_sel3", start_3, 0);

        // empty sections; load_req from RUN drops start next cycle
        pulse_load();
        chk("t2_start_drop", start, 0);
        s = {8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        chk("t2_start", start, 1);
        chk("t2_sel2", start_2, 0);

        // oversize icount
        pulse_load();
        s = {8'h01, 8'h02};
        send_stream(s, 0);
        chk("t3_error", error, 1);
        chk("t3_ready", rx_ready, 0);
        chk("t3_busy", busy, 0);
        @(negedge clock);
        chk("t3_error_sticky", error, 1);
        pulse_load();
        chk("t3_error_clr", error, 0);
        chk("t3_busy_again", busy, 1);

        // same image with rx_valid toggling (already in ICNT_LO)
        iram_q.push_back({9'd0, 16'h1234});
        iram_q.push_back({9'd1, 16'h5678});
        dram_q.push_back({9'd0, 16'hBEEF});
        s = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h01, 8'h00, 8'hEF, 8'hBE};
        send_stream(s, 1);
        wait_start();

        // reset during I_HI of word 3
        iram_q.push_back({9'd0, 16'h1111});
        iram_q.push_back({9'd1, 16'h2222});
        pulse_load();
        s = {8'h04, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33};
        send_stream(s, 0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("t5_start", start, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", rx_ready, 0);
        chk("t5_sel2", start_2, 0);
        chk("t5_addr", addr_ext, 0);
        chk("t5_data", data_ins, 0);
        chk("t5_iq_empty", iram_q.size(), 0);
        iram_q.push_back({9'd0, 16'hABCD});
        iram_q.push_back({9'd1, 16'hEF01});
        pulse_load();
        s = {8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'hEF, 8'h00, 8'h00};
        send_stream(s, 0);
        chk("t5_reload_start", start, 1);

        // full-size instruction section
        pulse_load();
        s = {8'h00, 8'h02};
        for (int i = 0; i < 512; i++) begin
            w = (i == 511) ? 16'hA5A5 : 16'(i);
            iram_q.push_back({9'(i), w});
            s.push_back(w[7:0]);
            s.push_back(w[15:8]);
        end
        s.push_back(8'h00);
        s.push_back(8'h00);
        send_stream(s, 0);
        chk("t6_start", start, 1);
        chk("t6_error", error, 0);
        chk("t6_last_addr", addr_ext, 9'h1FF);
        chk("t6_last_data", data_ins, 16'hA5A5);
        pulse_load();
        chk("t6_start_drop", start, 0);
        chk("t6_ready", rx_ready, 1);

        chk("iram_q_drained", iram_q.size(), 0);
        chk("dram_q_drained", dram_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the multicore top-level memory-load interface.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit words, low byte first.
- Writes an instruction section into IRAM through the start_2 path, then a data section into DRAM through the start_3 path.
- Then holds the processor start level high until a new load is requested.

Parameters:
- ADDR_W, 9, external address width (matches addr_ext)
- DATA_W, 16, memory word width
- MAX_WORDS, 512, largest legal section word count; a larger count is an error

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset
- load_req  in  1  single-cycle pulse; begins a new load from IDLE, RUN or ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- addr_ext  out  ADDR_W  IRAM/DRAM word address
- start_2  out  1  IRAM external-load select
- iram_write_ext  out  1  IRAM write request
- data_ins  out  DATA_W  IRAM write data
- start_3  out  1  DRAM external-load select
- dram_write_ext  out  1  DRAM write request
- data_dram  out  DATA_W  DRAM write data
- start  out  1  processor run level
- busy  out  1  load in progress (any state except IDLE, RUN, ERR)
- error  out  1  oversize section count seen; sticky

Behaviour:
- Reset (reset_n=0 at a clock edge, including mid-load):
  - state to IDLE.
  - Every output to 0; data and address registers to 0.
  - A partially loaded image is abandoned, with no further writes.
- Byte transfer: a byte is consumed only on a cycle where rx_valid=1 and rx_ready=1.
- rx_ready is 1 only in the byte-collecting states: ICNT_LO, ICNT_HI, I_LO, I_HI, DCNT_LO, DCNT_HI, D_LO, D_HI.
- Stream format: icount (2 bytes, LSB first), icount words (each LSB then MSB), dcount (2 bytes), dcount words.
- State sequence:
  - IDLE -(load_req)-> ICNT_LO -> ICNT_HI.
  - After ICNT_HI:
    - count > MAX_WORDS -> ERR
    - count == 0 -> DCNT_LO
    - otherwise -> I_LO, with addr reset to 0
  - Instruction words: I_LO -> I_HI -> I_WR -> I_HOLD.
  - After I_HOLD: if addr == icount-1 -> DCNT_LO; otherwise increment addr and return to I_LO.
  - DCNT_LO -> DCNT_HI.
  - After DCNT_HI:
    - count > MAX_WORDS -> ERR
    - count == 0 -> RUN
    - otherwise -> D_LO, with addr reset to 0
  - Data words: D_LO -> D_HI -> D_WR -> D_HOLD.
  - After D_HOLD: if addr == dcount-1 -> RUN; otherwise increment addr and return to D_LO.
- Write timing: the downstream block registers the address and write enable one cycle after the select, while IRAM data is taken unregistered. Each word therefore occupies two cycles:
  - I_WR: start_2=1, iram_write_ext=1.
  - I_HOLD: start_2=1, iram_write_ext=0.
  - addr_ext and data_ins are stable across both cycles and unchanged until the next word's I_WR.
  - D_WR/D_HOLD follow the same pattern with start_3, dram_write_ext and data_dram.
- Exclusivity:
  - start_2, start_3 and start are never 1 in the same cycle.
  - start_2/start_3 are 0 outside their WR/HOLD states.
- RUN: start=1, registered and held every cycle.
  - load_req in RUN: start=0 on the next cycle, state to ICNT_LO.
  - Memory contents are overwritten only as new words arrive.
- ERR: error=1, start=0, rx_ready=0. Only load_req or reset leaves ERR; load_req clears error and goes to ICNT_LO.
- load_req during a busy state is ignored.
- Counts are 16-bit; a count exactly equal to MAX_WORDS is legal (addresses 0..511).
- Per-word throughput: 4 cycles minimum (2 bytes + WR + HOLD); stalls whenever rx_valid is low.

Decomposition:
- Shared package loader_pkg:
  - state enumeration (15 states)
  - ADDR_W, DATA_W, MAX_WORDS defaults
  - byte-order constant
- Sub-module word_assembler:
  - captures the LSB/MSB bytes into a DATA_W register under a lo/hi strobe from the FSM
  - reused for both count fields and both data sections

Test Plan:
- Reset then load_req; stream 02 00 | 34 12 | 78 56 | 01 00 | EF BE -> expected response:
  - IRAM[0]=0x1234, IRAM[1]=0x5678, DRAM[0]=0xBEEF
  - start=1 the cycle after the final D_HOLD; busy=0
- icount=0 and dcount=0 (00 00 00 00) -> no start_2/start_3 pulses; start=1 directly after DCNT_HI.
- icount=0x0201 -> error=1 and ERR entered after ICNT_HI; rx_ready=0; a following load_req clears error.
- rx_valid toggled 1/0 every cycle during word bytes -> identical memory contents; per-byte acceptance only when valid&&ready.
- reset_n=0 for one cycle during I_HI of word 3 -> all outputs 0 next cycle; a new load_req with a full stream loads correctly from address 0.
- icount=512 with the last word 0xA5A5 -> addr_ext reaches 0x1FF with IRAM[511]=0xA5A5, no wrap to 0 and no error; load_req asserted during RUN drops start within 1 cycle.
